mem_arb_ctrl: RTL and testbench

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rr.sv | 40 ++++
 rtl/mem_arb_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory arbiter/controller
//
// Holds the controller FSM state encoding and the requester (owner)
// encoding used by mem_arb_ctrl and mem_arb_rr.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin grant with last-grant register
//
// Ports:
//   iClock, iReset - clock, synchronous active-high reset
//   req_ifu        - IFU is requesting
//   req_lsu        - LSU is requesting
//   accept         - the granted request was handshaken this cycle
//   grant          - requester currently favoured (combinational)
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   iClock,
    input  logic   iReset,
    input  logic   req_ifu,
    input  logic   req_lsu,
    input  logic   accept,
    output owner_t grant
);

    owner_t last_grant;

    // Reset to LSU so the first tie after reset goes to the IFU.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            last_grant <= OWNER_LSU;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    always_comb begin
        grant = OWNER_IFU;
        if (req_ifu && req_lsu) begin
            grant = (last_grant == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
        end else if (req_lsu) begin
            grant = OWNER_LSU;
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// rtl/mem_arb_ctrl.sv - IFU/LSU arbiter driving a synchronous memory
//
// Ports:
//   iClock, iReset        - clock, synchronous active-high reset
//   pIfu_bReq*            - fetch request (valid/ready/addr)
//   pIfu_bRespValid       - fetch response pulse, data on pResp_bData
//   pLsu_bReq*            - load/store request (valid/ready/wr/addr/data/mask)
//   pLsu_bRespValid       - load data / store ack pulse
//   pResp_bData           - shared response data
//   pMem_b*               - memory command, pMem_bRdData one cycle after RdEn
//
// Configuration: MEM_ARB_FIXED_PRIO_EN - LSU wins every tie, no round-robin.
//
// One transaction every three cycles: IDLE (handshake) -> ISSUE (memory
// command) -> RESP (response pulse).
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  pIfu_bReqValid,
    output logic                  pIfu_bReqReady,
    input  logic [ADDR_WIDTH-1:0] pIfu_bReqAddr,
    output logic                  pIfu_bRespValid,
    input  logic                  pLsu_bReqValid,
    output logic                  pLsu_bReqReady,
    input  logic                  pLsu_bReqWr,
    input  logic [ADDR_WIDTH-1:0] pLsu_bReqAddr,
    input  logic [DATA_WIDTH-1:0] pLsu_bReqData,
    input  logic [3:0]            pLsu_bReqMask,
    output logic                  pLsu_bRespValid,
    output logic [DATA_WIDTH-1:0] pResp_bData,
    output logic                  pMem_bRdEn,
    output logic                  pMem_bWrEn,
    output logic [ADDR_WIDTH-1:0] pMem_bAddr,
    output logic [DATA_WIDTH-1:0] pMem_bWrData,
    output logic [3:0]            pMem_bWrMask,
    input  logic [DATA_WIDTH-1:0] pMem_bRdData
);

    state_t                state;
    state_t                state_next;
    owner_t                grant;
    owner_t                owner;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            mask_q;
    logic                  accept;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant = pLsu_bReqValid ? OWNER_LSU : OWNER_IFU;
`else
    mem_arb_rr u_rr (
        .iClock  (iClock),
        .iReset  (iReset),
        .req_ifu (pIfu_bReqValid),
        .req_lsu (pLsu_bReqValid),
        .accept  (accept),
        .grant   (grant)
    );
`endif

    // No handshake while reset is held: the request would be dropped anyway.
    assign accept = (state == ST_IDLE) && !iReset &&
                    (((grant == OWNER_IFU) && pIfu_bReqValid) ||
                     ((grant == OWNER_LSU) && pLsu_bReqValid));

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= ST_IDLE;
            owner  <= OWNER_IFU;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= grant;
                if (grant == OWNER_LSU) begin
                    wr_q   <= pLsu_bReqWr;
                    addr_q <= pLsu_bReqAddr;
                    data_q <= pLsu_bReqData;
                    mask_q <= pLsu_bReqMask;
                end else begin
                    wr_q   <= 1'b0;
                    addr_q <= pIfu_bReqAddr;
                    data_q <= '0;
                    mask_q <= '0;
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        pIfu_bReqReady  = 1'b0;
        pLsu_bReqReady  = 1'b0;
        pIfu_bRespValid = 1'b0;
        pLsu_bRespValid = 1'b0;
        pResp_bData     = '0;
        pMem_bRdEn      = 1'b0;
        pMem_bWrEn      = 1'b0;
        pMem_bAddr      = '0;
        pMem_bWrData    = '0;
        pMem_bWrMask    = '0;
        case (state)
            ST_IDLE: begin
                pIfu_bReqReady = accept && (grant == OWNER_IFU);
                pLsu_bReqReady = accept && (grant == OWNER_LSU);
                if (accept) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_RESP;
                if (!iReset) begin
                    pMem_bRdEn   = !wr_q;
                    pMem_bWrEn   = wr_q;
                    pMem_bAddr   = addr_q;
                    pMem_bWrData = data_q;
                    pMem_bWrMask = mask_q;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
                if (!iReset) begin
                    pIfu_bRespValid = (owner == OWNER_IFU);
                    pLsu_bRespValid = (owner == OWNER_LSU);
                    pResp_bData     = wr_q ? '0 : pMem_bRdData;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb/tb_mem_arb_ctrl.sv - directed self-checking bench for mem_arb_ctrl
module tb_mem_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid, ifu_ready, ifu_resp;
    logic [31:0] ifu_addr;
    logic        lsu_valid, lsu_ready, lsu_wr, lsu_resp;
    logic [31:0] lsu_addr, lsu_data;
    logic [3:0]  lsu_mask;
    logic [31:0] resp_data;
    logic        rd_en, wr_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    logic [31:0] mem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arb_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iClock          (clk),
        .iReset          (rst),
        .pIfu_bReqValid  (ifu_valid),
        .pIfu_bReqReady  (ifu_ready),
        .pIfu_bReqAddr   (ifu_addr),
        .pIfu_bRespValid (ifu_resp),
        .pLsu_bReqValid  (lsu_valid),
        .pLsu_bReqReady  (lsu_ready),
        .pLsu_bReqWr     (lsu_wr),
        .pLsu_bReqAddr   (lsu_addr),
        .pLsu_bReqData   (lsu_data),
        .pLsu_bReqMask   (lsu_mask),
        .pLsu_bRespValid (lsu_resp),
        .pResp_bData     (resp_data),
        .pMem_bRdEn      (rd_en),
        .pMem_bWrEn      (wr_en),
        .pMem_bAddr      (mem_addr),
        .pMem_bWrData    (mem_wdata),
        .pMem_bWrMask    (mem_mask),
        .pMem_bRdData    (mem_rdata)
    );

    // Synchronous word memory; a store writes the whole word.
    always @(posedge clk) begin
        if (rd_en) mem_rdata <= mem[mem_addr[9:2]];
        if (wr_en) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {ifu_ready, lsu_ready, ifu_resp, lsu_resp, resp_data,
                rd_en, wr_en, mem_addr, mem_wdata, mem_mask};
    endfunction

    // Advance to just after the next rising edge; checks happen 4ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
        ifu_valid = 1'b1; ifu_addr = addr;
        #4;
        check_val("fetch_ready", {ifu_ready, lsu_ready}, 2'b10);
        tick();
        ifu_valid = 1'b0; ifu_addr = 32'hFFFF_FFFC;
        #4;
        check_val("fetch_issue", {rd_en, wr_en, mem_addr}, {2'b10, addr});
        tick();
        #4;
        check_val("fetch_resp", {ifu_resp, lsu_resp, resp_data}, {2'b10, exp});
        tick();
    endtask

    task automatic do_lsu(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [31:0] exp);
        lsu_valid = 1'b1; lsu_wr = wr; lsu_addr = addr; lsu_data = data; lsu_mask = mask;
        #4;
        check_val("lsu_ready", {ifu_ready, lsu_ready}, 2'b01);
        tick();
        lsu_valid = 1'b0; lsu_wr = ~wr; lsu_addr = 32'h0; lsu_data = 32'h0; lsu_mask = 4'h0;
        #4;
        check_val("lsu_issue", {rd_en, wr_en, mem_addr, mem_wdata, mem_mask},
                  {~wr, wr, addr, data, mask});
        tick();
        #4;
        check_val("lsu_resp", {ifu_resp, lsu_resp, resp_data}, {2'b01, exp});
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_0013;
        mem_rdata = 32'h0;
        rst = 1'b1;
        ifu_valid = 1'b0; ifu_addr = 32'h0;
        lsu_valid = 1'b0; lsu_wr = 1'b0; lsu_addr = 32'h0; lsu_data = 32'h0; lsu_mask = 4'h0;
        tick(); tick();
        #4;
        check_val("reset_outs", all_outs(), 128'h0);
        tick();
        rst = 1'b0;
        #4;
        check_val("idle_outs", all_outs(), 128'h0);
        tick();

        do_fetch(32'h8000_0000, 32'h0000_0013);
        #4;
        check_val("after_fetch_idle", all_outs(), 128'h0);
        tick();

        do_lsu(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        do_lsu(1'b0, 32'h8000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF);
        do_lsu(1'b1, 32'h8000_0200, 32'h0000_1234, 4'b0011, 32'h0);
        do_lsu(1'b1, 32'h8000_0204, 32'h0055_0066, 4'b0101, 32'h0);
        do_lsu(1'b0, 32'h8000_0204, 32'h0,         4'b0000, 32'h0055_0066);

        // Both requesters valid from reset onward.
        rst = 1'b1;
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_valid = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0100; lsu_mask = 4'hF;
        #4;
        check_val("rst_ready_low", {ifu_ready, lsu_ready}, 2'b00);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic exp_ifu;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_ifu = 1'b0;
`else
            exp_ifu = (k % 2 == 0);
`endif
            #4;
            check_val($sformatf("rr_grant%0d", k), {ifu_ready, lsu_ready}, {exp_ifu, ~exp_ifu});
            tick();
            #4;
            check_val($sformatf("rr_issue_ready%0d", k), {ifu_ready, lsu_ready, rd_en}, 3'b001);
            tick();
            #4;
            check_val($sformatf("rr_resp%0d", k), {ifu_resp, lsu_resp, resp_data},
                      {exp_ifu, ~exp_ifu, exp_ifu ? 32'h0000_0013 : 32'hDEAD_BEEF});
            tick();
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        // Reset while a fetch is in ISSUE: command dropped, no response.
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #4;
        check_val("abort_ready", {ifu_ready, lsu_ready}, 2'b10);
        tick();
        ifu_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #4;
        check_val("abort_outs", all_outs(), 128'h0);
        tick();
        #4;
        check_val("abort_no_resp", all_outs(), 128'h0);
        tick();
        do_fetch(32'h8000_0000, 32'h0000_0013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
